// File: rtl/golden_risky_pkg.sv
// Shared constants, encodings and instruction builders for the GoldenRisky core.
package golden_risky_pkg;

   localparam int INSTRUCTION_SIZE = 16;
   localparam int ADDRESS_SIZE     = 10;
   localparam int DATA_SIZE        = 32;
   localparam int REG_COUNT        = 8;

   // Register indices
   localparam logic [2:0] R0 = 3'd0;
   localparam logic [2:0] R1 = 3'd1;
   localparam logic [2:0] R2 = 3'd2;
   localparam logic [2:0] R3 = 3'd3;
   localparam logic [2:0] R4 = 3'd4;
   localparam logic [2:0] R5 = 3'd5;
   localparam logic [2:0] R6 = 3'd6;
   localparam logic [2:0] R7 = 3'd7;

   // Opcodes (field widths differ per instruction class)
   localparam logic [2:0] OP_ALU     = 3'b001;
   localparam logic [6:0] OP_SHIFTR  = 7'b0100000;
   localparam logic [6:0] OP_SHIFTRA = 7'b0100001;
   localparam logic [6:0] OP_SHIFTL  = 7'b0100010;
   localparam logic [6:0] OP_LOAD    = 7'b0101000;
   localparam logic [6:0] OP_STORE   = 7'b0101001;
   localparam logic [4:0] OP_LOADC   = 5'b01100;
   localparam logic [6:0] OP_JMP     = 7'b1000000;
   localparam logic [6:0] OP_JMPR    = 7'b1000001;
   localparam logic [3:0] OP_JMPC    = 4'b1001;
   localparam logic [3:0] OP_JMPRC   = 4'b1010;

   // ALU selects
   localparam logic [3:0] SEL_ADD  = 4'd0;
   localparam logic [3:0] SEL_ADDF = 4'd1;
   localparam logic [3:0] SEL_SUB  = 4'd2;
   localparam logic [3:0] SEL_SUBF = 4'd3;
   localparam logic [3:0] SEL_AND  = 4'd4;
   localparam logic [3:0] SEL_OR   = 4'd5;
   localparam logic [3:0] SEL_XOR  = 4'd6;
   localparam logic [3:0] SEL_NAND = 4'd7;
   localparam logic [3:0] SEL_NOR  = 4'd8;
   localparam logic [3:0] SEL_XNOR = 4'd9;

   // Condition codes
   localparam logic [2:0] COND_N  = 3'b000;
   localparam logic [2:0] COND_NN = 3'b001;
   localparam logic [2:0] COND_Z  = 3'b010;
   localparam logic [2:0] COND_NZ = 3'b011;

   localparam logic [15:0] NOP_INST  = 16'h0000;
   localparam logic [15:0] HALT_INST = 16'hFFFF;

   // Internal ALU operation selector
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NAND, ALU_NOR,
      ALU_XNOR, ALU_SHR, ALU_SRA, ALU_SHL, ALU_PASS
   } alu_op_e;

   // Branch condition evaluation from the flags of the condition register
   function automatic logic cond_taken(input logic [2:0] cond, input logic neg, input logic zero);
      logic taken;
      case (cond)
         COND_N:  taken = neg;
         COND_NN: taken = ~neg;
         COND_Z:  taken = zero;
         COND_NZ: taken = ~zero;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   // Instruction builders
   function automatic logic [15:0] ALU_INST(input logic [3:0] sel, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [2:0] rb);
      return {OP_ALU, sel, rd, ra, rb};
   endfunction
   function automatic logic [15:0] ADD_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_ADD, rd, ra, rb);
   endfunction
   function automatic logic [15:0] ADDF_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_ADDF, rd, ra, rb);
   endfunction
   function automatic logic [15:0] SUB_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_SUB, rd, ra, rb);
   endfunction
   function automatic logic [15:0] SUBF_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_SUBF, rd, ra, rb);
   endfunction
   function automatic logic [15:0] AND_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_AND, rd, ra, rb);
   endfunction
   function automatic logic [15:0] OR_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_OR, rd, ra, rb);
   endfunction
   function automatic logic [15:0] XOR_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_XOR, rd, ra, rb);
   endfunction
   function automatic logic [15:0] NAND_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_NAND, rd, ra, rb);
   endfunction
   function automatic logic [15:0] NOR_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_NOR, rd, ra, rb);
   endfunction
   function automatic logic [15:0] XNOR_INST(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
      return ALU_INST(SEL_XNOR, rd, ra, rb);
   endfunction
   function automatic logic [15:0] SHIFTR_INST(input logic [2:0] rd, input logic [5:0] shamt);
      return {OP_SHIFTR, rd, shamt};
   endfunction
   function automatic logic [15:0] SHIFTRA_INST(input logic [2:0] rd, input logic [5:0] shamt);
      return {OP_SHIFTRA, rd, shamt};
   endfunction
   function automatic logic [15:0] SHIFTL_INST(input logic [2:0] rd, input logic [5:0] shamt);
      return {OP_SHIFTL, rd, shamt};
   endfunction
   function automatic logic [15:0] LOAD_INST(input logic [2:0] rd, input logic [2:0] ra);
      return {OP_LOAD, rd, 3'b000, ra};
   endfunction
   function automatic logic [15:0] STORE_INST(input logic [2:0] ra, input logic [2:0] rs);
      return {OP_STORE, ra, 3'b000, rs};
   endfunction
   function automatic logic [15:0] LOADC_INST(input logic [2:0] rd, input logic [7:0] c);
      return {OP_LOADC, rd, c};
   endfunction
   function automatic logic [15:0] JMP_INST(input logic [2:0] ra);
      return {OP_JMP, 6'b000000, ra};
   endfunction
   function automatic logic [15:0] JMPR_INST(input logic [5:0] off);
      return {OP_JMPR, 3'b000, off};
   endfunction
   function automatic logic [15:0] JMPC_INST(input logic [2:0] cond, input logic [2:0] rc, input logic [2:0] ra);
      return {OP_JMPC, cond, rc, 3'b000, ra};
   endfunction
   function automatic logic [15:0] JMPRC_INST(input logic [2:0] cond, input logic [2:0] rc, input logic [5:0] off);
      return {OP_JMPRC, cond, rc, off};
   endfunction

endpackage

// File: rtl/golden_risky_alu.sv
// Combinational 32-bit ALU: logic/arithmetic ops, shifts and pass-through
// with negative/zero flags taken from the result.
module golden_risky_alu
   import golden_risky_pkg::*;
(
   input  alu_op_e               op,
   input  logic [DATA_SIZE-1:0]  a,
   input  logic [DATA_SIZE-1:0]  b,
   input  logic [5:0]            shamt,
   output logic [DATA_SIZE-1:0]  result,
   output logic                  negative,
   output logic                  zero
);

   // Operation select; shift amounts of 32 or more saturate (shamt[5] set)
   always_comb begin
      result = 32'd0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_NAND: result = ~(a & b);
         ALU_NOR:  result = ~(a | b);
         ALU_XNOR: result = ~(a ^ b);
         ALU_SHR:  result = shamt[5] ? 32'd0 : (a >> shamt[4:0]);
         ALU_SRA:  result = shamt[5] ? {32{a[31]}} : 32'($signed(a) >>> shamt[4:0]);
         ALU_SHL:  result = shamt[5] ? 32'd0 : (a << shamt[4:0]);
         ALU_PASS: result = a;
         default:  result = 32'd0;
      endcase
   end

   assign negative = result[31];
   assign zero     = (result == 32'd0);

endmodule

// File: rtl/golden_risky_core.sv
// GoldenRisky CPU: single-cycle 16-bit-instruction load/store core with an
// 8x32 register file and a 10-bit word-addressed program counter.
module golden_risky_core
   import golden_risky_pkg::*;
(
   input  logic                         clock,
   input  logic                         reset,
   input  logic [INSTRUCTION_SIZE-1:0]  instruction,
   output logic [ADDRESS_SIZE-1:0]      pc,
   output logic                         read,
   output logic                         write,
   output logic [ADDRESS_SIZE-1:0]      address,
   output logic [DATA_SIZE-1:0]         data_out,
   input  logic [DATA_SIZE-1:0]         data_in
);

   logic [ADDRESS_SIZE-1:0]                pc_r;
   logic [REG_COUNT-1:0][DATA_SIZE-1:0]    regs_r;
   logic [ADDRESS_SIZE-1:0]                next_pc_s;
   logic                                   wr_en_s;
   logic [2:0]                             wr_idx_s;
   logic [DATA_SIZE-1:0]                   wr_data_s;
   alu_op_e                                alu_op_s;
   logic [DATA_SIZE-1:0]                   alu_a_s;
   logic [DATA_SIZE-1:0]                   alu_b_s;
   logic [DATA_SIZE-1:0]                   alu_res_s;
   logic                                   alu_neg_s;
   logic                                   alu_zero_s;
   logic [ADDRESS_SIZE-1:0]                pc_inc_s;
   logic [ADDRESS_SIZE-1:0]                pc_rel_s;

   assign pc       = pc_r;
   assign pc_inc_s = pc_r + 10'd1;
   assign pc_rel_s = pc_r + {{4{instruction[5]}}, instruction[5:0]};

   // ALU operand/operation steering; jumps pass the condition register through for flags
   always_comb begin
      alu_op_s = ALU_PASS;
      alu_a_s  = 32'd0;
      alu_b_s  = regs_r[instruction[2:0]];
      case (instruction[15:13])
         OP_ALU: begin
            alu_a_s = regs_r[instruction[5:3]];
            case (instruction[12:9])
               SEL_ADD, SEL_ADDF: alu_op_s = ALU_ADD;
               SEL_SUB, SEL_SUBF: alu_op_s = ALU_SUB;
               SEL_AND:           alu_op_s = ALU_AND;
               SEL_OR:            alu_op_s = ALU_OR;
               SEL_XOR:           alu_op_s = ALU_XOR;
               SEL_NAND:          alu_op_s = ALU_NAND;
               SEL_NOR:           alu_op_s = ALU_NOR;
               SEL_XNOR:          alu_op_s = ALU_XNOR;
               default:           alu_op_s = ALU_PASS;
            endcase
         end
         3'b010: begin
            alu_a_s = regs_r[instruction[8:6]];
            case (instruction[15:9])
               OP_SHIFTR:  alu_op_s = ALU_SHR;
               OP_SHIFTRA: alu_op_s = ALU_SRA;
               OP_SHIFTL:  alu_op_s = ALU_SHL;
               default:    alu_op_s = ALU_PASS;
            endcase
         end
         3'b100, 3'b101: alu_a_s = regs_r[instruction[8:6]];
         default:        alu_a_s = 32'd0;
      endcase
   end

   golden_risky_alu u_alu (
      .op       (alu_op_s),
      .a        (alu_a_s),
      .b        (alu_b_s),
      .shamt    (instruction[5:0]),
      .result   (alu_res_s),
      .negative (alu_neg_s),
      .zero     (alu_zero_s)
   );

   // Instruction decode: next pc, register writeback and data-memory strobes
   always_comb begin
      next_pc_s = pc_inc_s;
      wr_en_s   = 1'b0;
      wr_idx_s  = instruction[8:6];
      wr_data_s = alu_res_s;
      read      = 1'b0;
      write     = 1'b0;
      address   = 10'd0;
      data_out  = 32'd0;
      if (instruction == HALT_INST) begin
         next_pc_s = pc_r;
      end else begin
         case (instruction[15:13])
            OP_ALU: begin
               if (instruction[12:9] <= SEL_XNOR) begin
                  wr_en_s = 1'b1;
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            3'b010: begin
               case (instruction[15:9])
                  OP_SHIFTR, OP_SHIFTRA, OP_SHIFTL: wr_en_s = 1'b1;
                  OP_LOAD: begin
                     read      = 1'b1;
                     address   = regs_r[instruction[2:0]][ADDRESS_SIZE-1:0];
                     wr_en_s   = 1'b1;
                     wr_data_s = data_in;
                  end
                  OP_STORE: begin
                     write    = 1'b1;
                     address  = regs_r[instruction[8:6]][ADDRESS_SIZE-1:0];
                     data_out = regs_r[instruction[2:0]];
                  end
                  default: wr_en_s = 1'b0;
               endcase
            end
            3'b011: begin
               if (instruction[15:11] == OP_LOADC) begin
                  wr_en_s   = 1'b1;
                  wr_idx_s  = instruction[10:8];
                  wr_data_s = {24'd0, instruction[7:0]};
               end else begin
                  wr_en_s = 1'b0;
               end
            end
            3'b100: begin
               if (instruction[15:9] == OP_JMP) begin
                  next_pc_s = regs_r[instruction[2:0]][ADDRESS_SIZE-1:0];
               end else if (instruction[15:9] == OP_JMPR) begin
                  next_pc_s = pc_rel_s;
               end else if (instruction[15:12] == OP_JMPC) begin
                  if (cond_taken(instruction[11:9], alu_neg_s, alu_zero_s)) begin
                     next_pc_s = regs_r[instruction[2:0]][ADDRESS_SIZE-1:0];
                  end else begin
                     next_pc_s = pc_inc_s;
                  end
               end else begin
                  next_pc_s = pc_inc_s;
               end
            end
            3'b101: begin
               if ((instruction[15:12] == OP_JMPRC) &&
                   cond_taken(instruction[11:9], alu_neg_s, alu_zero_s)) begin
                  next_pc_s = pc_rel_s;
               end else begin
                  next_pc_s = pc_inc_s;
               end
            end
            default: next_pc_s = pc_inc_s;
         endcase
      end
   end

   // Architectural state: pc and register file, cleared asynchronously by reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_r   <= 10'd0;
         regs_r <= '0;
      end else begin
         pc_r <= next_pc_s;
         if (wr_en_s) begin
            regs_r[wr_idx_s] <= wr_data_s;
         end
      end
   end

endmodule

// File: tb/tb_golden_risky_core.sv
// Scoreboard bench for golden_risky_core: a behavioural model predicts the
// per-cycle outputs, a monitor compares them against the DUT.
module tb_golden_risky_core;
   import golden_risky_pkg::*;

   typedef struct {
      logic [9:0]  pc;
      logic        rd;
      logic        wr;
      logic [9:0]  addr;
      logic [31:0] dout;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] instruction = 16'h0000;
   logic [31:0] data_in = 32'h0;
   logic [9:0]  pc;
   logic        read, write;
   logic [9:0]  address;
   logic [31:0] data_out;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail  = 0;

   logic [31:0] m_reg [8];
   int          m_pc;

   golden_risky_core dut (
      .clock(clock), .reset(reset), .instruction(instruction), .pc(pc),
      .read(read), .write(write), .address(address), .data_out(data_out),
      .data_in(data_in)
   );

   always #5 clock = ~clock;

   function automatic bit cond_ok(input int cond, input logic [31:0] v);
      case (cond)
         0: return $signed(v) < 0;
         1: return $signed(v) >= 0;
         2: return v == 0;
         3: return v != 0;
         default: return 0;
      endcase
   endfunction

   // Reference model: predicts this cycle's outputs, then applies the edge update
   task automatic model_cycle(input logic [15:0] ins, input logic [31:0] din, input bit held);
      exp_t e;
      int npc, sh, off, rd, sel;
      bit wr;
      logic [31:0] nv, a, b, v;
      e.pc = 10'(m_pc); e.rd = 1'b0; e.wr = 1'b0; e.addr = 10'd0; e.dout = 32'd0;
      npc = (m_pc + 1) % 1024;
      wr = 0; nv = 32'd0; rd = int'(ins[8:6]);
      sh = int'(ins[5:0]);
      off = int'(ins[5:0]); if (off >= 32) off = off - 64;
      v = m_reg[ins[8:6]];
      if (ins == 16'hFFFF) begin
         npc = m_pc;
      end else if (ins[15:13] == 3'b001) begin
         sel = int'(ins[12:9]); a = m_reg[ins[5:3]]; b = m_reg[ins[2:0]]; wr = 1;
         case (sel)
            0, 1: nv = a + b;
            2, 3: nv = a - b;
            4: nv = a & b;
            5: nv = a | b;
            6: nv = a ^ b;
            7: nv = ~(a & b);
            8: nv = ~(a | b);
            9: nv = ~(a ^ b);
            default: wr = 0;
         endcase
      end else if (ins[15:9] == 7'b0100000) begin
         wr = 1; nv = (sh >= 32) ? 32'd0 : v >> sh;
      end else if (ins[15:9] == 7'b0100001) begin
         wr = 1;
         if (v[31]) nv = (sh >= 32) ? 32'hFFFFFFFF : ~((~v) >> sh);
         else       nv = (sh >= 32) ? 32'd0 : v >> sh;
      end else if (ins[15:9] == 7'b0100010) begin
         wr = 1; nv = (sh >= 32) ? 32'd0 : v << sh;
      end else if (ins[15:9] == 7'b0101000) begin
         e.rd = 1'b1; e.addr = 10'(m_reg[ins[2:0]] % 1024); wr = 1; nv = din;
      end else if (ins[15:9] == 7'b0101001) begin
         e.wr = 1'b1; e.addr = 10'(m_reg[ins[8:6]] % 1024); e.dout = m_reg[ins[2:0]];
      end else if (ins[15:11] == 5'b01100) begin
         wr = 1; rd = int'(ins[10:8]); nv = {24'd0, ins[7:0]};
      end else if (ins[15:9] == 7'b1000000) begin
         npc = int'(m_reg[ins[2:0]] % 1024);
      end else if (ins[15:9] == 7'b1000001) begin
         npc = (m_pc + off + 1024) % 1024;
      end else if (ins[15:12] == 4'b1001) begin
         if (cond_ok(int'(ins[11:9]), v)) npc = int'(m_reg[ins[2:0]] % 1024);
      end else if (ins[15:12] == 4'b1010) begin
         if (cond_ok(int'(ins[11:9]), v)) npc = (m_pc + off + 1024) % 1024;
      end
      exp_q.push_back(e);
      if (!held) begin
         m_pc = npc;
         if (wr) m_reg[rd] = nv;
      end
   endtask

   task automatic issue(input logic [15:0] ins, input logic [31:0] din);
      @(negedge clock);
      reset = 1'b0;
      instruction = ins;
      data_in = din;
      model_cycle(ins, din, 1'b0);
   endtask

   // Reset asserted between edges and held across one rising edge
   task automatic do_reset();
      logic [15:0] ins;
      @(negedge clock);
      reset = 1'b1;
      ins = 16'($urandom);
      instruction = ins;
      data_in = $urandom;
      m_pc = 0;
      for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
      model_cycle(ins, data_in, 1'b1);
   endtask

   task automatic dump_regs();
      for (int i = 0; i < 8; i++) issue(STORE_INST(3'(i), 3'(i)), $urandom);
   endtask

   function automatic logic [15:0] rand_inst();
      logic [2:0] r1, r2, r3;
      r1 = 3'($urandom_range(0, 7)); r2 = 3'($urandom_range(0, 7)); r3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 11))
         0:  return LOADC_INST(r1, 8'($urandom));
         1:  return ALU_INST(4'($urandom_range(0, 15)), r1, r2, r3);
         2:  case ($urandom_range(0, 2))
                0: return SHIFTR_INST(r1, 6'($urandom_range(0, 63)));
                1: return SHIFTRA_INST(r1, 6'($urandom_range(0, 63)));
                default: return SHIFTL_INST(r1, 6'($urandom_range(0, 63)));
             endcase
         3:  return LOAD_INST(r1, r2);
         4:  return STORE_INST(r1, r2);
         5:  return JMP_INST(r1);
         6:  return JMPR_INST(6'($urandom));
         7:  return JMPC_INST(r3, r1, r2);
         8:  return JMPRC_INST(r3, r1, 6'($urandom));
         9:  return NOP_INST;
         10: return HALT_INST;
         default: return 16'($urandom);
      endcase
   endfunction

   // Monitor: compare each predicted cycle with the DUT outputs mid-cycle
   initial begin
      forever begin
         @(negedge clock);
         #2;
         while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (pc !== mon_e.pc || read !== mon_e.rd || write !== mon_e.wr ||
                address !== mon_e.addr || data_out !== mon_e.dout) begin
               n_fail++;
               $display("FAIL cycle_outputs t=%0t: got pc=%h rd=%b wr=%b addr=%h dout=%h, expected pc=%h rd=%b wr=%b addr=%h dout=%h",
                        $time, pc, read, write, address, data_out,
                        mon_e.pc, mon_e.rd, mon_e.wr, mon_e.addr, mon_e.dout);
            end
         end
      end
   end

   initial begin
      logic [7:0] plan_c [8];
      plan_c = '{8'hD, 8'hE, 8'hA, 8'hD, 8'hB, 8'hA, 8'hB, 8'hE};
      m_pc = 0;
      for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
      do_reset();
      dump_regs();
      do_reset();
      // Directed program
      for (int i = 0; i < 8; i++) issue(LOADC_INST(3'(i), plan_c[i]), 32'd0);
      issue(ADD_INST(R0, R1, R2), 32'd0);
      issue(SUB_INST(R7, R5, R6), 32'd0);
      issue(ADDF_INST(R6, R7, R3), 32'd0);
      issue(SUBF_INST(R1, R5, R6), 32'd0);
      issue(AND_INST(R3, R1, R3), 32'd0);
      issue(OR_INST(R2, R6, R0), 32'd0);
      issue(XOR_INST(R4, R1, R0), 32'd0);
      issue(NAND_INST(R5, R2, R3), 32'd0);
      issue(NOR_INST(R0, R4, R6), 32'd0);
      issue(XNOR_INST(R3, R1, R5), 32'd0);
      issue(SHIFTR_INST(R4, 6'd3), 32'd0);
      issue(SHIFTRA_INST(R1, 6'd4), 32'd0);
      issue(SHIFTL_INST(R6, 6'd2), 32'd0);
      issue(LOAD_INST(R0, R6), 32'hDEADBEEF);
      issue(STORE_INST(R2, R4), 32'd0);
      dump_regs();
      issue(JMP_INST(R6), 32'd0);
      issue(JMPR_INST(6'd20), 32'd0);
      issue(JMPR_INST(6'b110110), 32'd0);
      issue(JMPC_INST(COND_N, R3, R2), 32'd0);
      issue(JMPRC_INST(COND_NN, R6, 6'd5), 32'd0);
      issue(JMPRC_INST(COND_Z, R6, 6'd7), 32'd0);
      for (int i = 0; i < 10; i++) issue(NOP_INST, 32'd0);
      for (int i = 0; i < 10; i++) issue(HALT_INST, 32'd0);
      do_reset();
      dump_regs();
      do_reset();
      for (int i = 0; i < 8; i++) issue(LOADC_INST(3'(i), plan_c[i]), 32'd0);
      for (int i = 0; i < 4; i++) issue(HALT_INST, 32'd0);
      dump_regs();
      // Saturating shifts on a negative value
      issue(LOAD_INST(R5, R0), 32'h80000001);
      issue(SHIFTRA_INST(R5, 6'd40), 32'd0);
      issue(LOAD_INST(R6, R0), 32'h80000001);
      issue(SHIFTR_INST(R6, 6'd32), 32'd0);
      issue(LOAD_INST(R7, R0), 32'h80000001);
      issue(SHIFTRA_INST(R7, 6'd31), 32'd0);
      dump_regs();
      // Randomized traffic with a mid-run reset
      for (int n = 0; n < 600; n++) begin
         if (n == 300) do_reset();
         issue(rand_inst(), $urandom);
         if (n % 100 == 99) dump_regs();
      end
      dump_regs();
      repeat (3) @(negedge clock);
      #4;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/golden_risky_core.md
Name: golden_risky_core

Overview:
Single-cycle, non-pipelined 32-bit load/store processor core with 8 general registers (R0-R7), 16-bit instructions and a 10-bit word-addressed PC. It fetches from an external program memory, which returns `instruction` combinationally for the current `pc`. It accesses an external data memory through read/write strobes. It is the CPU block of the GoldenRisky system; memories are external.

Parameters:
INSTRUCTION_SIZE, 16, instruction width
ADDRESS_SIZE, 10, PC and data-address width
DATA_SIZE, 32, register/data width
REG_COUNT, 8, number of general registers (3-bit index)

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears pc and register file
instruction  input  16  instruction at current pc
pc  output  10  program counter
read  output  1  high while current instruction is LOAD
write  output  1  high while current instruction is STORE
address  output  10  data address (low 10 bits of address register)
data_out  output  32  store data
data_in  input  32  load data, sampled at the rising edge ending a LOAD

Behaviour:
- Reset asserted: pc=0 and R0-R7=0 immediately. read/write=0, address=0 and data_out=0 whenever the instruction is not LOAD/STORE.
- Exactly one instruction executes per clock. Register write and pc update happen on the rising edge. read/write/address/data_out are combinational from `instruction` and registers.
- Default next pc = pc+1. The pc is 10 bits and wraps modulo 1024. All jump targets and relative sums are also truncated to 10 bits.
- Encoding: fields are bit ranges of the instruction. Any unlisted pattern executes as NOP.
- NOP 16'h0000: pc+1 only.
- HALT 16'hFFFF: pc and registers hold. The core stays halted while HALT is presented and resumes on any other instruction or on reset.
- ALU ops [15:13]=001: sel[12:9], rd[8:6], ra[5:3], rb[2:0]; rd = ra op rb.
  - sel: 0 ADD, 1 ADDF, 2 SUB, 3 SUBF, 4 AND, 5 OR, 6 XOR, 7 NAND, 8 NOR, 9 XNOR.
  - ADDF/SUBF are implemented as 32-bit integer add/sub, identical to ADD/SUB; there is no floating-point unit.
  - Arithmetic wraps mod 2^32. sel 10-15 behave as NOP.
- Shifts [15:9]=0100000 SHIFTR (logical right), 0100001 SHIFTRA (arithmetic right), 0100010 SHIFTL (left).
  - Fields: rd[8:6], shamt[5:0] unsigned; rd = rd shifted by shamt.
  - shamt >= 32 gives 0, or all sign bits for SHIFTRA.
- LOAD [15:9]=0101000: rd[8:6], ra[2:0]; read=1, address=ra[9:0]; rd <= data_in at the edge.
- STORE [15:9]=0101001: ra[8:6] (address), rs[2:0] (data); write=1, address=ra[9:0], data_out=rs. No register changes.
- LOADC [15:11]=01100: rd[10:8], const[7:0]; rd = zero-extended const.
- JMP [15:9]=1000000: ra[2:0]; pc = ra[9:0].
- JMPR [15:9]=1000001: off[5:0] signed; pc = pc + sign-extended off.
- JMPcond [15:12]=1001: cond[11:9], rc[8:6], ra[2:0]; if cond(rc) then pc = ra[9:0], else pc+1.
- JMPRcond [15:12]=1010: cond[11:9], rc[8:6], off[5:0]; if cond(rc) then pc = pc + off, else pc+1.
- cond codes: 000 N (rc<0 signed), 001 NN (rc>=0), 010 Z (rc==0), 011 NZ (rc!=0). Codes 100-111 are never taken.
- Register reads return the pre-edge value. A write to rd takes effect at the edge, and a read of the same register in the same instruction sees the old value.
- Reset mid-instruction aborts it; no register or pc update from that cycle.

Decomposition:
- Package golden_risky_pkg holds:
  - width constants;
  - register indices R0-R7;
  - opcode/ALU-select/condition-code localparams;
  - NOP_INST/HALT_INST constants and instruction-building functions (ADD_INST, LOADC_INST, ...) for benches.
- One sub-module, golden_risky_alu: combinational 32-bit ALU covering the ALU ops and shifts, with a negative/zero flag for jump conditions.

Test Plan:
- Reset, then LOADC R0..R7 with D,E,A,D,B,A,B,E -> registers hold those values; pc increments 0->8.
- ADD R0,R1,R2 then SUB R7,R5,R6 then ADDF R6,R7,R3 then SUBF R1,R5,R6 -> R0=0x18, R7=0xFFFFFFFF, R6=0xC, R1=0xFFFFFFFE.
- Logic chain:
  - AND R3,R1,R3 -> R3=0xC
  - OR R2,R6,R0 -> R2=0x1C
  - XOR R4,R1,R0 -> R4=0xFFFFFFE6
  - NAND R5,R2,R3 -> R5=0xFFFFFFF3
  - NOR R0,R4,R6 -> R0=0x11
  - XNOR R3,R1,R5 -> R3=0xFFFFFFF2
- Shifts and memory:
  - SHIFTR R4,3 -> R4=0x1FFFFFFC
  - SHIFTRA R1,4 -> R1=0xFFFFFFFF
  - SHIFTL R6,2 -> R6=0x30
  - LOAD R0,R6 with data_in=0xDEADBEEF -> read=1, address=0x30, R0=0xDEADBEEF
  - STORE R2,R4 -> write=1, address=0x1C, data_out=0x1FFFFFFC
- Jumps: JMP R6 -> pc=0x30; JMPR 20 -> 0x44; JMPR -10 -> 0x3A; JMPN R3,R2 -> 0x1C; JMPRNN R6,5 -> 0x21; JMPRZ on a nonzero register -> pc+1.
- NOP x10 -> pc advances by 10. HALT x10 -> pc frozen. Reset -> pc=0 and all registers 0. Then run an 8-LOADC program followed by HALT -> pc stops at 8.
